grf_wb_arbiter: RTL and testbench

- Write-side companion of the general register file.
- Merges two writeback producers into the GRF's single write port (gwe/gwa/gwd plus W_pc for the trace):
  - the in-order pipeline W stage, which has priority and is never stalled;
  - a late auxiliary producer, such as a multi-cycle multiply/divide unit, buffered in a small FIFO behind a valid/ready handshake.
- Exposes per-register pending flags so the D-stage hazard unit can stall reads of registers whose auxiliary write is still queued.

---
 rtl/grf_wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges the in-order pipeline writeback (priority, never stalled) and a
// buffered auxiliary producer into the single GRF write port. Queued auxiliary writes
// are reported per source register so the D-stage hazard unit can stall on them.
// Optional simulation-only diagnostics: define GRF_WB_CONFLICT_CHECK_EN.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_data,
    input  logic [31:0]   wb_pc,
    input  logic          aux_valid,
    output logic          aux_ready,
    input  logic [4:0]    aux_addr,
    input  logic [31:0]   aux_data,
    input  logic [31:0]   aux_pc,
    output logic          gwe,
    output logic [4:0]    gwa,
    output logic [31:0]   gwd,
    output logic [31:0]   W_pc,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    output logic          rs_pending,
    output logic          rt_pending,
    output logic [CW-1:0] fifo_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    // FIFO storage; payload needs no reset because valid bits gate every use
    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [31:0]      fifo_pc   [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             gwe_d;
    logic [4:0]       gwa_d;
    logic [31:0]      gwd_d;
    logic [31:0]      w_pc_d;

    logic             wb_sel;
    logic             push;
    logic             pop;
    logic             push_killed;
    logic             head_live;

    assign aux_ready   = !reset && (count_q < DepthC);
    assign wb_sel      = wb_valid && (wb_addr != 5'd0);
    // Address 0 completes the handshake but never occupies a slot
    assign push        = aux_valid && aux_ready && (aux_addr != 5'd0);
    assign pop         = !wb_sel && (count_q != '0);
    assign push_killed = wb_sel && (aux_addr == wb_addr);
    assign head_live   = vld_q[rd_ptr_q] && !kill_q[rd_ptr_q];
    assign fifo_count  = count_q;

    // Commit selection: pipeline first, then FIFO head; killed head writes nothing
    always_comb begin
        gwe_d  = 1'b0;
        gwa_d  = gwa;
        gwd_d  = gwd;
        w_pc_d = W_pc;
        if (wb_sel) begin
            gwe_d  = 1'b1;
            gwa_d  = wb_addr;
            gwd_d  = wb_data;
            w_pc_d = wb_pc;
        end else if (pop && head_live) begin
            gwe_d  = 1'b1;
            gwa_d  = fifo_addr[rd_ptr_q];
            gwd_d  = fifo_data[rd_ptr_q];
            w_pc_d = fifo_pc[rd_ptr_q];
        end
    end

    // FIFO bookkeeping: kill matching live entries, retire head, append new entry
    always_comb begin
        vld_d    = vld_q;
        kill_d   = kill_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_sel && vld_q[i] && (fifo_addr[i] == wb_addr)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q]  = 1'b0;
            kill_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ptr_t'(rd_ptr_q + 1'b1);
        end
        if (push) begin
            vld_d[wr_ptr_q]  = 1'b1;
            kill_d[wr_ptr_q] = push_killed;
            wr_ptr_d         = ptr_t'(wr_ptr_q + 1'b1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pending flags: any live queued entry targeting the source register
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill_q[i]) begin
                if ((rs != 5'd0) && (fifo_addr[i] == rs)) rs_pending = 1'b1;
                if ((rt != 5'd0) && (fifo_addr[i] == rt)) rt_pending = 1'b1;
            end
        end
    end

    // Control state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            kill_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            gwe      <= 1'b0;
            gwa      <= 5'd0;
            gwd      <= 32'd0;
            W_pc     <= 32'd0;
        end else begin
            vld_q    <= vld_d;
            kill_q   <= kill_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            gwe      <= gwe_d;
            gwa      <= gwa_d;
            gwd      <= gwd_d;
            W_pc     <= w_pc_d;
        end
    end

    // Payload write on push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= aux_addr;
            fifo_data[wr_ptr_q] <= aux_data;
            fifo_pc[wr_ptr_q]   <= aux_pc;
        end
    end

`ifdef GRF_WB_CONFLICT_CHECK_EN
    int unsigned full_wait_q;

    // Diagnostics: FIFO commit colliding with a pipeline write, and long full stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_wait_q <= 0;
        end else begin
            if (pop && head_live && wb_valid && (fifo_addr[rd_ptr_q] == wb_addr)) begin
                $display("%d@%h: wb conflict $%d", $time, w_pc_d, gwa_d);
            end
            if (aux_valid && (count_q == DepthC)) begin
                full_wait_q <= full_wait_q + 1;
                if (full_wait_q == 64) begin
                    $display("%d: aux push held off by full FIFO for over 64 cycles", $time);
                end
            end else begin
                full_wait_q <= 0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Randomized scoreboard bench for grf_wb_arbiter against a queue-based reference model.
module tb_grf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [31:0]   wb_pc;
    logic          aux_valid;
    logic          aux_ready;
    logic [4:0]    aux_addr;
    logic [31:0]   aux_data;
    logic [31:0]   aux_pc;
    logic          gwe;
    logic [4:0]    gwa;
    logic [31:0]   gwd;
    logic [31:0]   W_pc;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rs_pending;
    logic          rt_pending;
    logic [CW-1:0] fifo_count;

    grf_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_addr   (aux_addr),
        .aux_data   (aux_data),
        .aux_pc     (aux_pc),
        .gwe        (gwe),
        .gwa        (gwa),
        .gwd        (gwd),
        .W_pc       (W_pc),
        .rs         (rs),
        .rt         (rt),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        bit          killed;
    } entry_t;

    typedef struct {
        logic        gwe;
        logic [4:0]  gwa;
        logic [31:0] gwd;
        logic [31:0] pc;
        int          count;
        logic        ready;
        logic        rs_p;
        logic        rt_p;
    } exp_t;

    // Reference model state
    entry_t      mq[$];
    logic        m_gwe;
    logic [4:0]  m_gwa;
    logic [31:0] m_gwd;
    logic [31:0] m_pc;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   held    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == r && !mq[i].killed) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_gwe = 0; m_gwa = '0; m_gwd = '0; m_pc = '0;
        held  = 0;
    endtask

    // One clock edge of the reference model; returns whether the aux offer was taken
    task automatic model_step(output bit accepted);
        bit     ready, wbsel;
        entry_t e;
        ready    = mq.size() < DEPTH;
        accepted = aux_valid && ready;
        wbsel    = wb_valid && (wb_addr != 0);
        if (wbsel) begin
            foreach (mq[i]) if (mq[i].addr == wb_addr) mq[i].killed = 1;
            m_gwe = 1; m_gwa = wb_addr; m_gwd = wb_data; m_pc = wb_pc;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.killed) m_gwe = 0;
            else begin
                m_gwe = 1; m_gwa = e.addr; m_gwd = e.data; m_pc = e.pc;
            end
        end else begin
            m_gwe = 0;
        end
        if (accepted && aux_addr != 0) begin
            e.addr   = aux_addr;
            e.data   = aux_data;
            e.pc     = aux_pc;
            e.killed = wbsel && (aux_addr == wb_addr);
            mq.push_back(e);
        end
    endtask

    // Monitor: compare DUT outputs after every edge for which an expectation was queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gwe", 32'(gwe), 32'(e.gwe));
                chk("gwa", 32'(gwa), 32'(e.gwa));
                chk("gwd", gwd, e.gwd);
                chk("W_pc", W_pc, e.pc);
                chk("fifo_count", 32'(fifo_count), 32'(e.count));
                chk("aux_ready", 32'(aux_ready), 32'(e.ready));
                chk("rs_pending", 32'(rs_pending), 32'(e.rs_p));
                chk("rt_pending", 32'(rt_pending), 32'(e.rt_p));
            end
        end
    end

    initial begin
        bit   acc;
        int   wb_pct;
        exp_t e;
        reset = 1; wb_valid = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
        aux_valid = 0; aux_addr = 0; aux_data = 0; aux_pc = 0; rs = 0; rt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_aux_ready", 32'(aux_ready), 32'd0);
        chk("reset_gwe", 32'(gwe), 32'd0);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_gwa", 32'(gwa), 32'd0);
        reset = 0;
        #1;
        chk("release_aux_ready", 32'(aux_ready), 32'd1);
        @(negedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 900 || cyc == 2100) begin
                // Asynchronous reset between edges: everything clears immediately
                reset = 1;
                #1;
                chk("async_gwe", 32'(gwe), 32'd0);
                chk("async_count", 32'(fifo_count), 32'd0);
                chk("async_aux_ready", 32'(aux_ready), 32'd0);
                chk("async_rs_pending", 32'(rs_pending), 32'd0);
                @(negedge clk);
                reset = 0;
                model_reset();
                aux_valid = 0;
            end
            unique case ((cyc / 150) % 3)
                0:       wb_pct = 10;
                1:       wb_pct = 50;
                default: wb_pct = 90;
            endcase
            wb_valid = ($urandom_range(99) < wb_pct);
            wb_addr  = 5'($urandom_range(7));
            wb_data  = $urandom;
            wb_pc    = $urandom & 32'hFFFF_FFFC;
            if (!held) begin
                aux_valid = ($urandom_range(99) < 60);
                aux_addr  = 5'($urandom_range(7));
                aux_data  = $urandom;
                aux_pc    = $urandom & 32'hFFFF_FFFC;
            end
            rs = 5'($urandom_range(7));
            rt = 5'($urandom_range(7));
            model_step(acc);
            held    = aux_valid && !acc;
            e.gwe   = m_gwe;
            e.gwa   = m_gwa;
            e.gwd   = m_gwd;
            e.pc    = m_pc;
            e.count = mq.size();
            e.ready = mq.size() < DEPTH;
            e.rs_p  = pending(rs);
            e.rt_p  = pending(rt);
            exp_q.push_back(e);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
